// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock, start/done handshake.
// Optional macro BOOTH_UNSIGNED_MODE_EN enables the signed_mode input; otherwise all operands are signed.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  // Handshake: start is accepted on a rising edge only while busy=0; done pulses
  // for one cycle, in which busy is already low, so start may be reissued then.
  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [QW-1:0]   q;
  logic [QW-1:0]   m;
  logic            q_1;
  logic [CW-1:0]   count;

  logic            ext_signed;
  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_next;
  logic [QW-1:0]   q_next;
  logic            q_1_next;

`ifdef BOOTH_UNSIGNED_MODE_EN
  assign ext_signed = signed_mode;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign ext_signed = 1'b1;
`endif

  assign busy  = (state == RUN);
  assign m_ext = {m[QW-1], m};

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    // Arithmetic right shift of {A,Q,Q_1} by one place
    acc_next = {sum[AW-1], sum[AW-1:1]};
    q_next   = {sum[0], q[QW-1:1]};
    q_1_next = q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {ext_signed & a[WIDTH-1], a};
            q     <= {ext_signed & b[WIDTH-1], b};
            acc   <= '0;
            q_1   <= 1'b0;
            count <= CW'(WIDTH + 1);
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          q_1   <= q_1_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            product <= {acc_next[WIDTH-2:0], q_next};
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: WIDTH=8 main instance plus a WIDTH=4 instance for MIN x MIN.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  exp_q[$];

  booth_mult_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy), .done(done), .product(product)
  );

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .signed_mode(1'b1), .busy(busy4), .done(done4), .product(product4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Driver: one WIDTH=8 operation, checks latency, done/busy and product
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                        input logic [15:0] expv, input string tag);
    int cyc;
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'h5A; b = 8'hA5; signed_mode = ~sm;
    check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_product"}, product, expv);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  // Scoreboard vectors for the held-start run: {a, b} pairs and expected products
  logic [7:0]  vec_a [6] = '{8'h03, 8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [7:0]  vec_b [6] = '{8'hFB, 8'h80, 8'h7F, 8'h7F, 8'h55, 8'h01};
  logic [15:0] vec_p [6] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h3F01, 16'h0000, 16'hFFFF};

  initial begin
    int cyc;
    int n_done;
    logic [15:0] exp_ff;
    logic [15:0] exp_c8;
    logic [7:0]  p4;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 16'h0000);
    check("reset_product4", product4, 8'h00);
    rst_n = 1'b1;

    run_op(8'h03, 8'hFB, 1'b1, 16'hFFF1, "s_3_x_m5");
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_x_min");
    run_op(8'h80, 8'h7F, 1'b1, 16'hC080, "s_min_x_max");

`ifdef BOOTH_UNSIGNED_MODE_EN
    exp_ff = 16'hFE01;
    exp_c8 = 16'h4E20;
`else
    exp_ff = 16'h0001;
    exp_c8 = 16'hEA20;
`endif
    run_op(8'hFF, 8'hFF, 1'b0, exp_ff, "u_ff_x_ff");
    run_op(8'hC8, 8'h64, 1'b0, exp_c8, "u_c8_x_64");
    run_op(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_x_m1");

    // WIDTH=4 instance: MIN x MIN and a mixed-sign pair
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a4 = (i == 0) ? 4'h8 : 4'h7;
      b4 = (i == 0) ? 4'h8 : 4'h9;
      p4 = (i == 0) ? 8'h40 : 8'hCF;
      start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      cyc = 0;
      while (!done4 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("w4_latency", cyc, 5);
      check("w4_product", product4, p4);
    end

    // Start pulses while busy are ignored
    @(negedge clk);
    a = 8'h02; b = 8'h03; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk);
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 5);
      a = 8'h07; b = 8'h07;
      if (done) n_done++;
    end
    start = 1'b0;
    check("busy_start_done_count", n_done, 1);
    check("busy_start_product", product, 16'h0006);

    // Reset mid-operation discards the result
    @(negedge clk);
    a = 8'h05; b = 8'h05; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midreset_no_done", n_done, 0);
    check("midreset_product_held", product, 16'h0000);
    run_op(8'h05, 8'h05, 1'b1, 16'h0019, "after_reset_5x5");

    // Start held high: one product per WIDTH+2 cycles, operands sampled on each accept
    foreach (vec_p[i]) exp_q.push_back(vec_p[i][15:8]);
    @(negedge clk);
    a = vec_a[0]; b = vec_b[0]; signed_mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!done) begin
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
        end
      end while (!done && cyc < 40);
      check("b2b_interval", cyc, 10);
      check("b2b_product_lo", product[7:0], vec_p[i][7:0]);
      check("b2b_product_hi", product[15:8], exp_q.pop_front());
      if (i < 5) begin
        a = vec_a[i+1]; b = vec_b[i+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
